// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: byte-stream command front end driving a 4-op ALU with an accumulator for chained ops
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] alu_sel,
  output logic       alu_oe,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;
  state_t     state;
  logic [7:0] acc;
  logic [3:0] cnt;
  // in_ready is high exactly in IDLE/LOAD_A/LOAD_B, so in_valid alone marks a transfer there
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      alu_oe    <= 1'b0;
      alu_sel   <= 2'b00;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      out_data  <= 8'h00;
      acc       <= 8'h00;
      cnt       <= 4'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          alu_sel <= in_data[1:0];
          busy    <= 1'b1;
          if (in_data[2]) begin
            alu_a <= acc;
            state <= LOAD_B;
          end else state <= LOAD_A;
        end
        LOAD_A: if (in_valid) begin
          alu_a <= in_data;
          state <= LOAD_B;
        end
        LOAD_B: if (in_valid) begin
          alu_b    <= in_data;
          cnt      <= 4'd0;
          in_ready <= 1'b0;
          alu_oe   <= 1'b1;
          state    <= EXEC;
        end
        EXEC: if (cnt == 4'(SETTLE_CYCLES - 1)) begin
          out_data  <= alu_result;
          acc       <= alu_result;
          alu_oe    <= 1'b0;
          out_valid <= 1'b1;
          state     <= RESP;
        end else cnt <= cnt + 4'd1;
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed checks of two sequencers (settle 1 and 4) against an arithmetic model
module tb_alu_op_sequencer;
  localparam int SET[2] = '{1, 4};
  logic       clk = 1'b0;
  logic       rst[2];
  logic [7:0] in_data[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic [7:0] out_data[2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [1:0] alu_sel[2];
  logic       alu_oe[2];
  logic [7:0] alu_a[2];
  logic [7:0] alu_b[2];
  logic [7:0] alu_result[2];
  logic       busy[2];
  int checks = 0;
  int errors = 0;
  int hs[2] = '{0, 0};
  int oe_cnt[2] = '{0, 0};
  int acc_m[2] = '{0, 0};
  int last;

  always #5 clk = ~clk;

  function automatic int alu_calc(input int op, input int a, input int b);
    case (op)
      0: return (a + b) & 255;
      1: return (a - b) & 255;
      2: return (b - a) & 255;
      default: return (a * b) & 255;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_op_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst[g]), .in_data(in_data[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .out_data(out_data[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .alu_sel(alu_sel[g]), .alu_oe(alu_oe[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_result(alu_result[g]), .busy(busy[g])
    );
    // a garbage value while the ALU is disabled exposes any premature sampling
    assign alu_result[g] = alu_oe[g] ? 8'(alu_calc(int'(alu_sel[g]), int'(alu_a[g]), int'(alu_b[g]))) : 8'hEE;
  end

  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (in_valid[g] && in_ready[g]) hs[g] <= hs[g] + 1;
      if (alu_oe[g]) oe_cnt[g] <= oe_cnt[g] + 1;
    end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    int t;
    repeat ($urandom_range(0, gap)) @(negedge clk);
    in_data[d] = b;
    in_valid[d] = 1'b1;
    for (t = 0; t < 50 && !in_ready[d]; t++) @(negedge clk);
    if (t == 50) chk("in_timeout", 0, 1);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic do_cmd(input int d, input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input int gap, input int hold);
    int h0, o0, lat, exp;
    exp = alu_calc(int'(cmd[1:0]), cmd[2] ? acc_m[d] : int'(a), int'(b));
    h0 = hs[d];
    send_byte(d, cmd, gap);
    if (!cmd[2]) send_byte(d, a, gap);
    send_byte(d, b, gap);
    o0 = oe_cnt[d];
    for (lat = 0; lat < 40 && !out_valid[d]; lat++) begin
      chk("exec_in_ready", int'(in_ready[d]), 0);
      @(negedge clk);
    end
    chk("latency", lat, SET[d]);
    chk("oe_cycles", oe_cnt[d] - o0, SET[d]);
    chk("bytes", hs[d] - h0, cmd[2] ? 2 : 3);
    chk("out_data", int'(out_data[d]), exp);
    chk("resp_oe", int'(alu_oe[d]), 0);
    if (hold > 0) begin
      in_data[d] = 8'h5A;
      in_valid[d] = 1'b1;
      repeat (hold) @(negedge clk);
      chk("hold_valid", int'(out_valid[d]), 1);
      chk("hold_data", int'(out_data[d]), exp);
      chk("hold_in_ready", int'(in_ready[d]), 0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b0;
    chk("valid_drop", int'(out_valid[d]), 0);
    chk("idle_ready", int'(in_ready[d]), 1);
    chk("idle_busy", int'(busy[d]), 0);
    chk("bytes_after", hs[d] - h0, cmd[2] ? 2 : 3);
    acc_m[d] = exp;
    last = exp;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      in_valid[d] = 1'b0;
      in_data[d] = 8'h00;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", int'(in_ready[d]), 1);
      chk("rst_valid", int'(out_valid[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_oe", int'(alu_oe[d]), 0);
      chk("rst_ab", int'({alu_sel[d], alu_a[d], alu_b[d], out_data[d]}), 0);
      rst[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      do_cmd(d, 8'h04, 8'h00, 8'h09, 0, 0); chk("chain_first", last, 8'h09);
      do_cmd(d, 8'h00, 8'h05, 8'h03, 0, 0); chk("add", last, 8'h08);
      do_cmd(d, 8'h01, 8'h03, 8'h05, 0, 0); chk("sub_wrap", last, 8'hFE);
      do_cmd(d, 8'h02, 8'h03, 8'h05, 0, 0); chk("rsub", last, 8'h02);
      do_cmd(d, 8'h03, 8'h10, 8'h11, 0, 0); chk("mul_trunc", last, 8'h10);
      do_cmd(d, 8'h04, 8'h00, 8'h02, 0, 0); chk("chain_add", last, 8'h12);
      do_cmd(d, 8'h00, 8'h05, 8'h03, 0, 5); chk("backpressure", last, 8'h08);
      do_cmd(d, 8'hF9, 8'h03, 8'h05, 3, 1); chk("gap_sub", last, 8'hFE);
      do_cmd(d, 8'h03, 8'h10, 8'h11, 3, 0); chk("gap_mul", last, 8'h10);
      do_cmd(d, 8'h04, 8'h00, 8'h02, 3, 2); chk("gap_chain", last, 8'h12);
    end
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h05, 0);
    send_byte(1, 8'h03, 0);
    @(negedge clk);
    chk("mid_exec_oe", int'(alu_oe[1]), 1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("mid_rst_oe", int'(alu_oe[1]), 0);
    chk("mid_rst_valid", int'(out_valid[1]), 0);
    chk("mid_rst_ready", int'(in_ready[1]), 1);
    chk("mid_rst_busy", int'(busy[1]), 0);
    chk("mid_rst_data", int'({alu_a[1], alu_b[1], out_data[1]}), 0);
    repeat (SET[1] + 2) @(negedge clk);
    chk("mid_rst_no_resp", int'(out_valid[1]), 0);
    acc_m[1] = 0;
    do_cmd(1, 8'h04, 8'h00, 8'h07, 0, 0); chk("rst_chain", last, 8'h07);
    for (int i = 0; i < 30; i++)
      for (int d = 0; d < 2; d++)
        do_cmd(d, 8'($urandom), 8'($urandom), 8'($urandom), 3, int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Byte-stream front end that drives the 4-instruction ALU: the command source on one side, the ALU's sel/oe/a/b/result interface on the other.
- Accepts a command byte and operand bytes over a valid/ready input port.
- Drives the ALU controls and captures the 8-bit result.
- Returns the result over a valid/ready output port.
- Keeps an accumulator so operations can be chained without reloading A.

Parameters:
SETTLE_CYCLES, 1, cycles alu_oe is held high before the result is captured (legal range 1..15).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_data  input  8  command/operand byte
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data this cycle
out_data  output  8  captured ALU result
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
alu_sel  output  2  ALU op select: 00 a+b, 01 a-b, 10 b-a, 11 a*b (low 8 bits)
alu_oe  output  1  ALU output enable
alu_a  output  8  ALU operand A
alu_b  output  8  ALU operand B
alu_result  input  8  ALU result bus (tri-stated by the ALU when alu_oe=0)
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Input transfer: a byte transfers on a rising clk edge with in_valid & in_ready.
- Output transfer: a result transfers on a rising clk edge with out_valid & out_ready.
- Command byte format:
  - bits[1:0] = op
  - bit2 = chain: A := accumulator, and no A byte is expected
  - bits[7:3] are ignored
- States:
  - IDLE: in_ready=1. On transfer, latch op into alu_sel and latch chain. If chain=1, load alu_a from acc and go to LOAD_B; otherwise go to LOAD_A.
  - LOAD_A: in_ready=1. On transfer, alu_a := in_data and go to LOAD_B.
  - LOAD_B: in_ready=1. On transfer, alu_b := in_data, go to EXEC, clear the settle counter.
  - EXEC: in_ready=0, alu_oe=1 for exactly SETTLE_CYCLES cycles. On the last EXEC cycle, out_data := alu_result and acc := alu_result; go to RESP.
  - RESP: alu_oe=0, out_valid=1, in_ready=0. Hold until out_ready, then go to IDLE with out_valid=0 the next cycle.
- alu_oe is 0 in every state except EXEC. The sequencer never samples alu_result while alu_oe=0.
- alu_sel, alu_a and alu_b are stable from entry to EXEC until the next command is accepted.
- Latency (SETTLE_CYCLES=1):
  - B accepted at edge n.
  - EXEC during cycle n..n+1.
  - out_valid rises after edge n+1.
  - Minimum command-to-result is 3 accepted bytes plus 1 settle cycle.
- Arithmetic: all arithmetic belongs to the ALU and is 8-bit wrap-around (sub underflow wraps; mult keeps the low byte). The sequencer passes bytes through unmodified.
- Boundary conditions:
  - in_valid held while in_ready=0 (EXEC/RESP): the byte is not consumed and must be presented again.
  - out_ready low indefinitely: the sequencer stays in RESP with out_data stable.
  - out_ready high already in the first RESP cycle: a 1-cycle out_valid pulse.
  - chain=1 as the first command after reset: A = acc = 0x00.
  - in_valid and out_ready together in RESP: only the output transfers; the input byte waits for IDLE.
- Reset: rst in any state (including mid-EXEC or RESP) sets the following on the next edge, and the pending operation is discarded:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - alu_oe=0, alu_sel=00
  - alu_a=alu_b=out_data=acc=0x00

Test Plan:
1. Add: cmd 0x00, A 0x05, B 0x03 -> out_data=0x08, one out_valid. alu_oe high exactly 1 cycle; out_valid one cycle after the last EXEC edge.
2. Sub wrap: cmd 0x01, A 0x03, B 0x05 -> 0xFE. Reverse sub: cmd 0x02, A 0x03, B 0x05 -> 0x02.
3. Mult truncation: cmd 0x03, A 0x10, B 0x11 -> 0x10. Chain: then cmd 0x04, B 0x02 -> 0x12, with only 2 bytes consumed.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data=0x08 held, in_ready=0, in_valid byte not consumed. out_ready=1 -> one transfer, then IDLE.
5. Reset mid-op: assert rst during EXEC with SETTLE_CYCLES=4 -> next edge alu_oe=0, out_valid=0, state IDLE. A following chain add with B=0x07 -> 0x07, since acc was cleared.
6. In_valid gaps: random idle cycles between the cmd/A/B bytes -> same results as scenarios 1–3, with no extra bytes consumed.
